// File: rtl/regfile_mp.sv
// Multi-port register file with dual write ports, N read ports,
// same-cycle write bypass and an FSM-driven full-array scrub.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset (starts a scrub)
//   clr_req        one-cycle pulse requesting a full scrub
//   busy           high while the scrub walks the array
//   we0/we1        write enables; port 1 wins on an address collision
//   waddr0/waddr1  write addresses
//   wdata0/wdata1  write data
//   re             per-port read enables
//   raddr          packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata          packed read data, port i at [i*DATA_W +: DATA_W]
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                w_scrub;
  logic                w_wr0;
  logic                w_wr1;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  assign busy = (r_state == S_CLEAR);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_scrub     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_scrub   = 1'b1;
        // Counter wraps back to 0 as the last entry is zeroed.
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == {ADDR_W{1'b1}})
          w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Entry 0 is hardwired to zero when ZR is set, so its writes are dropped.
  assign w_wr0 = we0 && !busy && !rst && !(ZR && waddr0 == '0);
  assign w_wr1 = we1 && !busy && !rst && !(ZR && waddr1 == '0);

  // Scrub and user writes never coexist: user writes are masked by busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_scrub) begin
        r_mem[r_cnt] <= '0;
      end else begin
        if (w_wr0) r_mem[waddr0] <= wdata0;
        if (w_wr1) r_mem[waddr1] <= wdata1;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;

    assign w_ra = raddr[g*ADDR_W +: ADDR_W];

    always_comb begin
      w_rd = '0;
      if (re[g] && !busy && !rst && !(ZR && w_ra == '0)) begin
        if (we1 && waddr1 == w_ra)
          w_rd = wdata1;
        else if (we0 && waddr0 == w_ra)
          w_rd = wdata0;
        else
          w_rd = r_mem[w_ra];
      end
    end

    assign rdata[g*DATA_W +: DATA_W] = w_rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build plus a
// DATA_W=16/ADDR_W=3/NUM_RD=4 build, scoreboard-checked.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst, clr_req, busy;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;

  logic        p_rst, p_clr, p_busy;
  logic        p_we0, p_we1;
  logic [2:0]  p_wa0, p_wa1;
  logic [15:0] p_wd0, p_wd1;
  logic [3:0]  p_re;
  logic [11:0] p_raddr;
  logic [63:0] p_rdata;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dut_p (
    .clk(clk), .rst(p_rst), .clr_req(p_clr), .busy(p_busy),
    .we0(p_we0), .we1(p_we1), .waddr0(p_wa0), .waddr1(p_wa1),
    .wdata0(p_wd0), .wdata1(p_wd1),
    .re(p_re), .raddr(p_raddr), .rdata(p_rdata)
  );

  function automatic logic [15:0] pf(int a);
    return 16'hC0DE ^ 16'(a * 257);
  endfunction

  task automatic expect_v(input logic [63:0] v);
    sb_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] got);
    logic [63:0] e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, got=%h", tag, got);
    end else begin
      e = sb_q.pop_front();
      assert (got === e) else begin
        errors++;
        $error("FAIL %s: got=%h exp=%h", tag, got, e);
      end
    end
  endtask

  // Counts negedges (including the current one) while busy stays high.
  task automatic wait_idle(input bit sel, output int n);
    n = 0;
    while ((sel ? p_busy : busy) && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, m;
    logic [63:0] ev;
    rst = 1'b1; clr_req = 0; we0 = 0; we1 = 0;
    waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
    re = 2'b11; raddr = 0;
    p_rst = 1'b1; p_clr = 0; p_we0 = 0; p_we1 = 0;
    p_wa0 = 0; p_wa1 = 0; p_wd0 = 0; p_wd1 = 0;
    p_re = 0; p_raddr = 0;

    // Reset and scrub length
    @(negedge clk);
    raddr = {5'd3, 5'd4};
    #1 expect_v(64'h0); chk("rst_rdata", rdata);
    @(negedge clk);
    rst = 1'b0;
    #1 expect_v(64'h1); chk("busy_after_rst", {63'h0, busy});
    wait_idle(1'b0, n);
    expect_v(64'd32); chk("scrub_len", 64'(n));
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1 expect_v(64'h0); chk($sformatf("zero_%0d", a), rdata);
    end

    // Write then read
    @(negedge clk);
    re = 2'b00; we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    we0 = 0; re = 2'b10; raddr = {5'd5, 5'd5};
    #1 expect_v({32'hDEADBEEF, 32'h0}); chk("wr_rd_p1", rdata);
    re = 2'b00;
    #1 expect_v(64'h0); chk("re_off", rdata);

    // Same-address dual write: port 1 wins
    @(negedge clk);
    we0 = 1; waddr0 = 7; wdata0 = 32'h11;
    we1 = 1; waddr1 = 7; wdata1 = 32'h22;
    re = 2'b01; raddr = {5'd0, 5'd7};
    #1 expect_v(64'h22); chk("conf_bypass", rdata);
    @(negedge clk);
    we0 = 0; we1 = 0;
    #1 expect_v(64'h22); chk("conf_stored", rdata);

    // Port-0 bypass
    @(negedge clk);
    we0 = 1; waddr0 = 9; wdata0 = 32'h33; raddr = {5'd0, 5'd9};
    #1 expect_v(64'h33); chk("byp0", rdata);
    @(negedge clk);
    we0 = 0;
    #1 expect_v(64'h33); chk("byp0_stored", rdata);

    // Zero register
    @(negedge clk);
    we1 = 1; waddr1 = 0; wdata1 = 32'hFFFFFFFF;
    re = 2'b11; raddr = 10'h0;
    #1 expect_v(64'h0); chk("zr_same", rdata);
    @(negedge clk);
    we1 = 0;
    #1 expect_v(64'h0); chk("zr_next", rdata);

    // Seed addr 3 so a dropped write is observable
    @(negedge clk);
    we0 = 1; waddr0 = 3; wdata0 = 32'h55;
    @(negedge clk);
    we0 = 0; re = 2'b01; raddr = {5'd0, 5'd3};
    #1 expect_v(64'h55); chk("seed3", rdata);

    // Scrub with write and clr_req mid-way
    @(negedge clk);
    clr_req = 1;
    @(negedge clk);
    clr_req = 0; raddr = {5'd0, 5'd9};
    #1 expect_v(64'h0); chk("busy_gate", rdata);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    we0 = 1; waddr0 = 3; wdata0 = 32'hAB; clr_req = 1;
    @(negedge clk);
    clr_req = 0;
    @(negedge clk);
    we0 = 0;
    wait_idle(1'b0, m);
    expect_v(64'd32); chk("scrub_norestart", 64'(5 + m));
    raddr = {5'd9, 5'd3}; re = 2'b11;
    #1 expect_v(64'h0); chk("drop_wr3", rdata);

    // rst at scrub cycle 10 restarts the full scrub
    @(negedge clk);
    clr_req = 1;
    @(negedge clk);
    clr_req = 0;
    repeat (9) @(negedge clk);
    rst = 1; we0 = 1; waddr0 = 4; wdata0 = 32'h77;
    @(negedge clk);
    rst = 0; we0 = 0;
    wait_idle(1'b0, m);
    expect_v(64'd32); chk("rst_restart", 64'(m));

    // Parametric build
    @(negedge clk);
    p_rst = 0;
    wait_idle(1'b1, n);
    expect_v(64'd8); chk("p_scrub_len", 64'(n));
    for (int a = 0; a < 8; a += 2) begin
      p_we0 = 1; p_wa0 = 3'(a);     p_wd0 = pf(a);
      p_we1 = 1; p_wa1 = 3'(a + 1); p_wd1 = pf(a + 1);
      @(negedge clk);
    end
    p_we0 = 0; p_we1 = 0; p_re = 4'hF;
    for (int base = 1; base <= 5; base += 4) begin
      ev = '0;
      for (int p = 0; p < 4; p++) begin
        int a;
        a = (base + p) % 8;
        p_raddr[p*3 +: 3] = 3'(a);
        ev[p*16 +: 16] = (a == 0) ? 16'h0 : pf(a);
      end
      #1 expect_v(ev); chk($sformatf("p_rd_%0d", base), p_rdata);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Parameters
REQ-001 SHALL provide DATA_W, default 32, register data width in bits.
REQ-002 SHALL provide ADDR_W, default 5, register address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL provide NUM_RD, default 2, number of independent read ports (1..8).
REQ-004 SHALL provide ZERO_REG, default 1, when 1 entry 0 reads as zero and ignores writes.

Interface
REQ-005 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have clr_req  input  1  one-cycle pulse requesting a full array scrub.
REQ-008 SHALL have busy  output  1  high while a scrub is in progress.
REQ-009 SHALL have we0, we1  input  1 each  write enables, ports 0 and 1.
REQ-010 SHALL have waddr0, waddr1  input  ADDR_W each  write addresses.
REQ-011 SHALL have wdata0, wdata1  input  DATA_W each  write data.
REQ-012 SHALL have re  input  NUM_RD  per-port read enable, bit i for port i.
REQ-013 SHALL have raddr  input  NUM_RD*ADDR_W  flattened read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-014 SHALL have rdata  output  NUM_RD*DATA_W  flattened read data; port i at bits [i*DATA_W +: DATA_W].

Function
REQ-015 SHALL perform reads combinationally, with no clock latency.
REQ-016 SHALL drive read port i to zero when re[i]=0, when busy=1, or when ZERO_REG=1 and raddr_i=0.
REQ-017 SHALL otherwise forward wdata1 when we1=1 and waddr1=raddr_i, else wdata0 when we0=1 and waddr0=raddr_i, else the stored value (same-cycle write bypass).
REQ-018 SHALL commit enabled writes at the rising edge; a write becomes visible through the array at the next cycle and through bypass in the same cycle.
REQ-019 SHALL resolve a same-address dual write with port 1 winning; no X and no merge.
REQ-020 SHALL drop writes to entry 0 when ZERO_REG=1, and bypass of address 0 SHALL still return zero.
REQ-021 SHALL implement a two-state FSM, IDLE and CLEAR, with an ADDR_W-bit scrub counter.
REQ-022 SHALL, in CLEAR, write zero to entry[counter] each cycle and increment the counter.
REQ-023 SHALL leave CLEAR for IDLE on the edge that zeroes entry DEPTH-1, taking exactly DEPTH cycles; busy SHALL then deassert.
REQ-024 SHALL, on IDLE with clr_req=1, enter CLEAR with the counter at 0 on the next edge.
REQ-025 SHALL ignore clr_req while in CLEAR; the scrub SHALL NOT restart.
REQ-026 SHALL ignore we0 and we1 while busy=1; writes are dropped, not queued.
REQ-027 SHALL keep user writes and scrub writes on one array with no write-port contention (scrub only when busy=1).

Reset
REQ-028 SHALL, on rst=1 at a rising edge, enter CLEAR with the counter at 0 and busy=1 from the following cycle, regardless of the current state.
REQ-029 SHALL restart the scrub from entry 0 if rst is asserted mid-scrub.
REQ-030 SHALL drive rdata all-zero while rst=1 or busy=1; the array holds all zeros DEPTH cycles after rst deasserts.
REQ-031 SHALL have rst take priority over clr_req and writes in the same cycle.

Verification
REQ-032 SHALL check scrub timing: rst 1 cycle, then idle -> busy high exactly 32 cycles (default params), then every entry reads 0 on both ports.
REQ-033 SHALL check write then read: we0, addr 5, data 0xDEADBEEF; next cycle read port 1 addr 5 -> 0xDEADBEEF; re[1]=0 -> 0.
REQ-034 SHALL check bypass and conflict: we0 addr 7 data 0x11 and we1 addr 7 data 0x22 in the same cycle, port 0 reading addr 7 -> 0x22 same cycle and after the edge.
REQ-035 SHALL check the zero register: we1 addr 0 data 0xFFFFFFFF -> reads of addr 0 return 0 in the same cycle and the next.
REQ-036 SHALL check a mid-scrub event: clr_req, then a write to addr 3 at cycle 4 of the scrub -> write dropped, addr 3 reads 0 after busy falls; rst at scrub cycle 10 -> busy stays high 32 more cycles.
REQ-037 SHALL check parametric builds: DATA_W=16, ADDR_W=3, NUM_RD=4, all ports reading distinct addresses after 8 writes -> each port returns its own address's data; scrub lasts 8 cycles.
